// File: rtl/sprite_draw_sched.sv
// sprite_draw_sched: shares one 8x8 sprite drawer between full-board refreshes and single-tile updates.
// Latency: begin_draw 3 cycles after an idle request; each tile occupies SETUP + ISSUE + DRAW_WAIT cycles.
// Backpressure: upd_ready = !full on the tile-update FIFO; refresh requests coalesce into one pending flag.
module sprite_draw_sched #(
  parameter int COLS       = 20,
  parameter int ROWS       = 15,
  parameter int DRAW_WAIT  = 65,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       refresh_req,
  input  logic       upd_valid,
  output logic       upd_ready,
  input  logic [4:0] upd_col,
  input  logic [3:0] upd_row,
  output logic [4:0] map_col,
  output logic [3:0] map_row,
  input  logic [2:0] map_sprite_id,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] sprite_id_out,
  output logic       begin_draw,
  output logic       busy,
  output logic       refresh_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DRAW_WAIT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(DRAW_WAIT - 1);
  localparam logic [4:0]    COL_LAST  = 5'(COLS - 1);
  localparam logic [3:0]    ROW_LAST  = 4'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ISSUE, WAIT} state_t;

  state_t        state;
  logic          mode_refresh;
  logic          refresh_pend;
  logic [4:0]    col;
  logic [3:0]    row;
  logic [CW-1:0] cnt;

  // Tile-update FIFO: {col,row} entries, pointers carry one extra wrap bit.
  logic [8:0]  fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        keep;
  logic        pop;
  logic        in_range;
  logic [8:0]  fifo_head;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign upd_ready  = !fifo_full;
  assign fifo_head  = fifo_mem[rd_ptr[AW-1:0]];

  // Off-board updates complete the handshake but never occupy a slot, so they can never draw.
  assign in_range = (32'(upd_col) < 32'(COLS)) && (32'(upd_row) < 32'(ROWS));
  assign push     = upd_valid && upd_ready;
  assign keep     = push && in_range;

  // A pending refresh always wins the IDLE decision, so the FIFO is only popped when none is pending.
  assign pop = (state == IDLE) && !refresh_pend && !fifo_empty;

  assign busy    = (state != IDLE);
  assign map_col = col;
  assign map_row = row;

  // FIFO storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (keep) begin
      fifo_mem[wr_ptr[AW-1:0]] <= {upd_col, upd_row};
    end
  end

  // FIFO pointers: push and pop in the same cycle are both honoured.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (keep) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Pending refresh: a request in the IDLE decision cycle survives the clear and is served next.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      refresh_pend <= 1'b0;
    end else begin
      refresh_pend <= refresh_req || (refresh_pend && (state != IDLE));
    end
  end

  // Scheduler FSM: pick a tile, latch its anchor and sprite id, pulse the drawer, wait out the draw.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      mode_refresh  <= 1'b0;
      col           <= '0;
      row           <= '0;
      cnt           <= '0;
      x_out         <= '0;
      y_out         <= '0;
      sprite_id_out <= '0;
      begin_draw    <= 1'b0;
      refresh_done  <= 1'b0;
    end else begin
      refresh_done <= 1'b0;
      case (state)
        IDLE: begin
          if (refresh_pend) begin
            mode_refresh <= 1'b1;
            col          <= '0;
            row          <= '0;
            state        <= SETUP;
          end else if (!fifo_empty) begin
            mode_refresh <= 1'b0;
            col          <= fifo_head[8:4];
            row          <= fifo_head[3:0];
            state        <= SETUP;
          end
        end
        SETUP: begin
          // map_sprite_id is the asynchronous map read of the registered col/row.
          sprite_id_out <= map_sprite_id;
          x_out         <= {col, 3'b000};
          y_out         <= {row, 3'b000};
          begin_draw    <= 1'b1;
          state         <= ISSUE;
        end
        ISSUE: begin
          begin_draw <= 1'b0;
          cnt        <= '0;
          state      <= WAIT;
        end
        WAIT: begin
          if (cnt == WAIT_LAST) begin
            cnt <= '0;
            if (!mode_refresh) begin
              state <= IDLE;
            end else if ((col == COL_LAST) && (row == ROW_LAST)) begin
              refresh_done <= 1'b1;
              state        <= IDLE;
            end else begin
              if (col == COL_LAST) begin
                col <= '0;
                row <= row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
              state <= SETUP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sprite_draw_sched.md
# sprite_draw_sched

Scheduler that sequences the 8x8 sprite drawer (`sprite_draw`) for the 160x120 Sokoban board. It shares the drawer between two requesters: a full-board refresh request and a small FIFO of single-tile updates from game logic. For each tile it reads the sprite id from the external tile map, then issues one `begin_draw` pulse with a stable anchor and id. It then waits out the drawer's fixed 64-pixel draw before issuing the next tile.

## Interface
Parameters:
- `COLS`, 20: board columns (160/8).
- `ROWS`, 15: board rows (120/8).
- `DRAW_WAIT`, 65: cycles held in WAIT after the issue cycle; covers the drawer's load and 64-pixel draw.
- `FIFO_DEPTH`, 4: tile-update FIFO entries (power of two).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock, shared with `sprite_draw`.
- `resetn`  in  1  asynchronous active-low reset.
- `refresh_req`  in  1  level/pulse; requests a full-board redraw.
- `upd_valid`  in  1  tile-update request valid.
- `upd_ready`  out  1  FIFO can accept; equals !full.
- `upd_col`  in  5  tile column of the update.
- `upd_row`  in  4  tile row of the update.
- `map_col`  out  5  tile-map read column (registered current tile).
- `map_row`  out  4  tile-map read row.
- `map_sprite_id`  in  3  tile-map data; asynchronous read of (`map_col`, `map_row`).
- `x_out`  out  8  drawer x anchor = col*8.
- `y_out`  out  7  drawer y anchor = row*8.
- `sprite_id_out`  out  3  drawer sprite id.
- `begin_draw`  out  1  drawer go; exactly one cycle high per tile.
- `busy`  out  1  high whenever state != IDLE.
- `refresh_done`  out  1  one-cycle pulse when the last tile of a refresh leaves WAIT.

## Operation
- States:
  - IDLE.
  - SETUP: capture `sprite_id_out`<=`map_sprite_id`, `x_out`<={col,3'b0}, `y_out`<={row,3'b0}.
  - ISSUE: `begin_draw`=1.
  - WAIT: counter runs 0..DRAW_WAIT-1.
- IDLE arbitration, refresh has priority:
  - If `refresh_pend`: clear it, set mode=REFRESH, col=row=0, go to SETUP.
  - Else if FIFO non-empty: pop, load col/row from the head entry, set mode=TILE, go to SETUP.
  - Else stay in IDLE.
- SETUP->ISSUE->WAIT unconditionally. WAIT exits when the counter reaches DRAW_WAIT-1:
  - TILE mode: go to IDLE.
  - REFRESH, not last tile: advance col (at COLS-1 wrap to 0 and row+1), go to SETUP.
  - REFRESH, last tile (col=COLS-1, row=ROWS-1): pulse `refresh_done`, go to IDLE.
- `refresh_pend` is set by `refresh_req`=1 in any cycle, including mid-refresh. Multiple requests coalesce into one pending refresh. A request arriving in the IDLE decision cycle is serviced from the next cycle.
- FIFO:
  - Push on `upd_valid`&&`upd_ready`.
  - An entry with col>=COLS or row>=ROWS is accepted but discarded.
  - Pushes continue during a refresh. Entries are not flushed; they redraw from the current map after the refresh.
  - Push and pop in the same cycle are both honoured. The pop is taken only from a non-empty FIFO.
- `x_out`, `y_out`, `sprite_id_out` change only in SETUP. They are held stable through ISSUE and WAIT.
- Width rules: col<COLS and row<ROWS, so x_out<=152 and y_out<=112. No overflow is possible.

## Timing
- Reset (async, immediate):
  - State IDLE.
  - All outputs 0; `upd_ready`=1.
  - FIFO empty, `refresh_pend`=0, counter 0.
- Reset asserted mid-draw aborts the sequence. `sprite_draw` shares `resetn`, so both restart cleanly.
- Per tile: SETUP 1 + ISSUE 1 + WAIT DRAW_WAIT = 67 cycles. Consecutive `begin_draw` pulses are therefore 67 cycles apart within a refresh.
- Latency:
  - Update accepted while idle: pushed at edge E, popped in IDLE at E+1, SETUP at E+2, `begin_draw` high in cycle E+3.
  - Refresh request while idle: `begin_draw` high 3 cycles after the `refresh_req` cycle.
- Full refresh: 300*67 = 20100 cycles from first SETUP to `refresh_done`.
- `begin_draw` always falls after one cycle. The drawer's ld_xys cycle follows, and its draw completes before the next pulse (DRAW_WAIT >= 65).

## Test plan
- Reset mid-WAIT -> all outputs 0, `busy`=0, `upd_ready`=1 immediately. FIFO empty after release.
- Single update (col 3, row 2), map returns id 5 -> exactly one `begin_draw`, x_out=24, y_out=16, sprite_id_out=5. Outputs stable for 66 cycles, then `busy` falls.
- `refresh_req` pulse -> 300 `begin_draw` pulses spaced 67 cycles apart. Anchors run raster order (0,0)..(152,112). `refresh_done` fires once, then `busy`=0.
- Push 5 updates back-to-back during a refresh -> `upd_ready` low after the 4th. After `refresh_done`, exactly 4 tile draws in FIFO order.
- Two `refresh_req` pulses during one refresh -> exactly one additional full refresh follows.
- Update (col 20, row 0) -> accepted, no draw issued, `busy` stays 0.
